// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game control path:
//   - UART command byte values
//   - pop FSM state encoding for the UART receive-FIFO reader
//   - paddle key encodings driven onto the pixel generator key bus
//   - decode_byte(): classifies a received byte into a command class
// ---------------------------------------------------------------------------
package pong_pkg;

  // Command bytes (ASCII)
  localparam logic [7:0] CMD_UP_L  = 8'h77;  // 'w'
  localparam logic [7:0] CMD_UP_U  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_DN_L  = 8'h73;  // 's'
  localparam logic [7:0] CMD_DN_U  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP  = 8'h78;  // 'x'
  localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'
  localparam logic [7:0] CMD_RST   = 8'h72;  // 'r'

  // Paddle key encodings; 2'b11 is never produced
  localparam logic [1:0] KEY_IDLE = 2'b00;
  localparam logic [1:0] KEY_UP   = 2'b01;
  localparam logic [1:0] KEY_DN   = 2'b10;

  // Pop FSM states. POP is the only state with bit 0 set, so the FIFO read
  // strobe can be taken straight from a register bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    GAP  = 2'b10
  } pop_state_t;

  // Command classes after decoding a byte
  typedef enum logic [2:0] {
    DEC_UP,
    DEC_DN,
    DEC_STOP,
    DEC_PAUSE,
    DEC_RST,
    DEC_BAD
  } dec_t;

  function automatic dec_t decode_byte(input logic [7:0] b);
    case (b)
      CMD_UP_L, CMD_UP_U: return DEC_UP;
      CMD_DN_L, CMD_DN_U: return DEC_DN;
      CMD_STOP:           return DEC_STOP;
      CMD_PAUSE:          return DEC_PAUSE;
      CMD_RST:            return DEC_RST;
      default:            return DEC_BAD;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Produces a single-clk tick once per video frame. The pixel position
// (pixel_x == 0, pixel_y == FRAME_LINE) may persist for several clk, so the
// registered match is edge-detected.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pixel_x, pixel_y  current pixel position from vga_sync
//   tick              one-clk pulse per frame
// ---------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int FRAME_LINE = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  output logic        tick
);

  logic match;
  logic match_q;
  logic match_q_d;

  assign match = (pixel_x == 12'd0) && (pixel_y == 12'(FRAME_LINE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q   <= 1'b0;
      match_q_d <= 1'b0;
    end else begin
      match_q   <= match;
      match_q_d <= match_q;
    end
  end

  assign tick = match_q & ~match_q_d;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Drains the UART receive FIFO (show-ahead) one byte per 3 clk and turns each
// byte into a player-2 paddle command or a game-control event. Paddle
// commands stay active for HOLD_FRAMES frame ticks.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pixel_x, pixel_y  pixel position, used for the per-frame tick
//   rx_empty          FIFO empty flag
//   rd_data           FIFO head byte, valid while rx_empty = 0
//   rd_uart           FIFO pop strobe, one clk wide
//   key_p2            paddle command: 01 up, 10 down, 00 idle
//   pause             pause level, toggled by 'p'
//   restart           one-clk pulse on 'r'
//   bad_cnt           saturating count of undecodable bytes
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import pong_pkg::*;
#(
  parameter int FRAME_LINE  = 500,
  parameter int HOLD_FRAMES = 4,
  parameter int HOLD_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  input  logic        rx_empty,
  input  logic [7:0]  rd_data,
  output logic        rd_uart,
  output logic [1:0]  key_p2,
  output logic        pause,
  output logic        restart,
  output logic [7:0]  bad_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  pop_state_t        state_q, state_d;
  logic              tick;
  logic [1:0]        cmd_q, cmd_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pause_d;
  logic              restart_d;
  logic [7:0]        bad_d;

  frame_tick_gen #(
    .FRAME_LINE(FRAME_LINE)
  ) u_frame_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .tick    (tick)
  );

  // -------------------------------------------------------------------------
  // Pop FSM: IDLE -> POP (strobe) -> GAP (let rx_empty settle) -> IDLE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_empty) state_d = POP;
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Taken directly from a flop output, so the strobe cannot glitch.
  assign rd_uart = state_q[0];

  // -------------------------------------------------------------------------
  // Hold countdown and command decode. A decode in the same cycle as a tick
  // overrides the countdown.
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_d     = cmd_q;
    hold_d    = hold_q;
    pause_d   = pause;
    restart_d = 1'b0;
    bad_d     = bad_cnt;

    if (tick && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_ONE;
      if (hold_q == HOLD_ONE) cmd_d = KEY_IDLE;
    end

    if (state_q == POP) begin
      case (decode_byte(rd_data))
        DEC_UP: begin
          cmd_d  = KEY_UP;
          hold_d = HOLD_LOAD;
        end
        DEC_DN: begin
          cmd_d  = KEY_DN;
          hold_d = HOLD_LOAD;
        end
        DEC_STOP: begin
          cmd_d  = KEY_IDLE;
          hold_d = '0;
        end
        DEC_PAUSE: pause_d = ~pause;
        DEC_RST: begin
          restart_d = 1'b1;
          pause_d   = 1'b0;
          cmd_d     = KEY_IDLE;
          hold_d    = '0;
        end
        default: if (bad_cnt != 8'hFF) bad_d = bad_cnt + 8'd1;
      endcase
    end
  end

  // key_p2 is registered from the next-state values so a decode is visible
  // one cycle after the pop, together with pause and restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q   <= KEY_IDLE;
      hold_q  <= '0;
      pause   <= 1'b0;
      restart <= 1'b0;
      bad_cnt <= 8'd0;
      key_p2  <= KEY_IDLE;
    end else begin
      cmd_q   <= cmd_d;
      hold_q  <= hold_d;
      pause   <= pause_d;
      restart <= restart_d;
      bad_cnt <= bad_d;
      key_p2  <= pause_d ? KEY_IDLE : cmd_d;
    end
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Owns the read side of the UART receive FIFO and turns incoming bytes into player-2 paddle commands plus game-control events.
- Drains the FIFO with a single-cycle rd_uart handshake and decodes each byte.
- Holds the paddle command for a programmable number of video frames.
- Sits between the uart block and the pixel generator; its key_p2 output feeds the upper two bits of the pixel generator's key bus.

Parameters:
FRAME_LINE, 500, pixel_y value at which the per-frame tick is generated (with pixel_x == 0).
HOLD_FRAMES, 4, number of frame ticks a w/s command stays active; legal range 1..2^HOLD_W-1.
HOLD_W, 4, width of the hold counter.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset; asynchronous assert, active-low.
pixel_x  in  12  current horizontal pixel from vga_sync.
pixel_y  in  12  current vertical line from vga_sync.
rx_empty  in  1  UART rx FIFO empty flag.
rd_data  in  8  UART rx FIFO head byte; show-ahead, valid whenever rx_empty=0.
rd_uart  out  1  pop strobe to the FIFO; one clk wide.
key_p2  out  2  paddle command: 01=up, 10=down, 00=idle; never 11.
pause  out  1  game pause level.
restart  out  1  one-clk restart pulse.
bad_cnt  out  8  count of undecodable bytes; saturates at 255.

Behaviour:
Reset values:
- reset_n=0 asynchronously clears all state: FSM=IDLE, key_p2=00, hold_cnt=0, pause=0, restart=0, rd_uart=0, bad_cnt=0.
- Reset mid-pop discards the byte in flight; the FIFO itself is not touched.

Frame tick:
- match = (pixel_x==0 && pixel_y==FRAME_LINE), registered as match_q.
- tick = match_q & ~match_q_d, i.e. a rising-edge detect.
- Exactly one tick per frame, even though pixel_x can stay at 0 for several clk.

Pop FSM (states IDLE, POP, GAP):
- IDLE: if rx_empty=0, go to POP next cycle.
- POP: rd_uart=1 (decoded from state, glitch-free); rd_data is captured on this edge; go to GAP.
- GAP: one dead cycle so the FIFO empty flag settles; go to IDLE.
- Throughput: at most 1 byte per 3 clk.
- Latency: rx_empty falls at cycle t; rd_uart is high at t+1; decoded outputs are visible at t+2.

Decode (applied to the byte captured in POP, effective on the next cycle):
- 0x77 'w' or 0x57 'W': cmd=01, hold_cnt=HOLD_FRAMES.
- 0x73 's' or 0x53 'S': cmd=10, hold_cnt=HOLD_FRAMES.
- 0x78 'x': cmd=00, hold_cnt=0.
- 0x70 'p': toggle pause.
- 0x72 'r': restart=1 for one clk; also clears pause, cmd and hold_cnt.
- Any other byte: bad_cnt+1, saturating; no other effect.

Hold:
- On tick with hold_cnt>0: hold_cnt-1; when it reaches 0, cmd=00.
- Tick with hold_cnt=0: no change.
- Tick and decode in the same cycle: decode wins (reload, no decrement).
- key_p2 = pause ? 00 : cmd, registered; the hold countdown continues while paused.

Boundary cases:
- Continuous FIFO data: bytes are processed strictly in order with no loss; rd_uart is never asserted while rx_empty=1.
- HOLD_FRAMES=1: command lasts until the next tick.

Decomposition:
- Shared package pong_pkg:
  - command byte localparams (CMD_UP_L/U, CMD_DN_L/U, CMD_STOP, CMD_PAUSE, CMD_RST);
  - pop FSM state encoding (IDLE/POP/GAP, 2 bits);
  - key encodings KEY_UP=01, KEY_DN=10, KEY_IDLE=00.
- One sub-module, frame_tick_gen: pixel compare plus edge detect, parameterised by FRAME_LINE; reusable by other per-frame logic.

Test Plan:
1. Push 0x77 into the FIFO; hold pixel_x=0/pixel_y=500 for 4 clk each frame -> rd_uart pulses once, key_p2=01 two clk after rx_empty falls, and stays 01 for exactly 4 ticks then 00 (1 tick per frame despite the 4-clk match).
2. Burst 0x73,0x41,0x73,0x78 back-to-back -> 4 rd_uart pulses each 3 clk apart; key_p2=10 then 00 after the 0x78 byte; bad_cnt=1.
3. Send 0x70 while key_p2=01 -> key_p2=00 and pause=1; send 0x70 before the hold expires -> key_p2=01 with remaining hold; send 0x72 -> restart pulse 1 clk, pause=0, key_p2=00.
4. Deliver a decode of 0x77 in the same cycle as a tick while hold_cnt=1 -> hold_cnt=HOLD_FRAMES and key_p2 stays 01 with no drop.
5. Send 300 bytes of 0xFF -> bad_cnt saturates at 255; rx_empty=1 throughout idle periods -> rd_uart never asserted.
6. Drive reset_n low during POP -> all outputs 0 immediately (asynchronous); after release the FSM pops the next FIFO byte normally.
